// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: MD funct codes, sequencer state encoding and MD-class decode
package mdu_ctrl_pkg;
  localparam logic [5:0] MD_MFHI  = 6'b010000;
  localparam logic [5:0] MD_MTHI  = 6'b010001;
  localparam logic [5:0] MD_MFLO  = 6'b010010;
  localparam logic [5:0] MD_MTLO  = 6'b010011;
  localparam logic [5:0] MD_MULT  = 6'b011000;
  localparam logic [5:0] MD_MULTU = 6'b011001;
  localparam logic [5:0] MD_DIV   = 6'b011010;
  localparam logic [5:0] MD_DIVU  = 6'b011011;
  typedef enum logic [1:0] {MDU_IDLE = 2'd0, MDU_MUL = 2'd1, MDU_DIV = 2'd2, MDU_FIX = 2'd3} mdu_state_e;
  function automatic logic is_md(input logic [5:0] f);
    return f inside {MD_MFHI, MD_MTHI, MD_MFLO, MD_MTLO, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step
module mdu_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         dbit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_o,
  output logic         q_bit
);
  logic [W:0] sh, diff;
  always_comb begin
    sh    = {rem_i, dbit};
    diff  = sh - {1'b0, divisor};
    q_bit = ~diff[W];
    rem_o = q_bit ? diff[W-1:0] : sh[W-1:0];
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle mult/div sequencer with HI/LO registers and pipeline stall
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam int CW = $clog2(DATA_W);
  mdu_state_e state, state_d;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] acc_hi, acc_lo, opb, raw_a;
  logic div_op, neg_res, neg_rem;
  logic start, is_div_f, sgn, a_neg, b_neg, last, q_bit;
  logic [DATA_W-1:0] abs_a, abs_b, rem_o, q_res, r_res, fix_hi, fix_lo;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W:0] sum;
  mdu_div_step #(.W(DATA_W)) u_step (
    .rem_i(acc_hi), .dbit(acc_lo[DATA_W-1]), .divisor(opb), .rem_o(rem_o), .q_bit(q_bit)
  );
  always_comb begin
    busy_o   = state != MDU_IDLE;
    stall_o  = valid_i & busy_o & is_md(funct_i);
    rdata_o  = funct_i == MD_MFHI ? hi_o : lo_o;
    start    = valid_i & ~flush_i & ~busy_o & (funct_i inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
    is_div_f = funct_i == MD_DIV || funct_i == MD_DIVU;
    sgn      = funct_i == MD_MULT || funct_i == MD_DIV;
    a_neg    = sgn & rs_data_i[DATA_W-1];
    b_neg    = sgn & rt_data_i[DATA_W-1];
    abs_a    = a_neg ? -rs_data_i : rs_data_i;
    abs_b    = b_neg ? -rt_data_i : rt_data_i;
    last     = count == CW'(DATA_W-1);
    state_d  = flush_i ? MDU_IDLE :
               state == MDU_IDLE ? (start ? (is_div_f ? MDU_DIV : MDU_MUL) : MDU_IDLE) :
               state == MDU_FIX ? MDU_IDLE : last ? MDU_FIX : state;
    sum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    prod     = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    q_res    = neg_res ? -acc_lo : acc_lo;
    r_res    = neg_rem ? -acc_hi : acc_hi;
    // a zero divisor reports all-ones quotient and the untouched dividend
    fix_hi   = div_op ? (opb == '0 ? raw_a : r_res) : prod[2*DATA_W-1:DATA_W];
    fix_lo   = div_op ? (opb == '0 ? '1 : q_res) : prod[DATA_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MDU_IDLE;
      count   <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opb     <= '0;
      raw_a   <= '0;
      div_op  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      state <= state_d;
      if (flush_i) count <= '0;
      else if (start) begin
        acc_hi  <= '0;
        acc_lo  <= abs_a;
        opb     <= abs_b;
        raw_a   <= rs_data_i;
        div_op  <= is_div_f;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        count   <= '0;
      end else if (state == MDU_MUL) begin
        {acc_hi, acc_lo} <= {sum, acc_lo[DATA_W-1:1]};
        count <= count + CW'(1);
      end else if (state == MDU_DIV) begin
        acc_hi <= rem_o;
        acc_lo <= {acc_lo[DATA_W-2:0], q_bit};
        count  <= count + CW'(1);
      end else if (state == MDU_FIX) begin
        hi_o <= fix_hi;
        lo_o <= fix_lo;
      end else if (valid_i && funct_i == MD_MTHI) hi_o <= rs_data_i;
      else if (valid_i && funct_i == MD_MTLO) lo_o <= rs_data_i;
    end
  end
endmodule
